// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : loader_pkg
//  Purpose  : Shared types and constants for the instruction loader.
//  Revision : 1.0 - initial release
// ============================================================================
package loader_pkg;

  // Number of stream bytes that make up the big-endian length header.
  localparam int HDR_BYTES = 4;

  // Loader FSM states (explicit 3-bit encoding).
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/loader_hdr_shift.sv
`default_nettype none
// ============================================================================
//  Module   : loader_hdr_shift
//  Purpose  : Assembles the 32-bit load length from header bytes, first byte
//             most significant. len_o already includes the byte presented
//             this cycle, so the caller can decide on the last header byte.
//  Revision : 1.0 - initial release
// ============================================================================
module loader_hdr_shift #(
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic [D_WIDTH-1:0] byte_i,
  output logic [31:0]        len_o
);

  logic [31:0] len_q;
  logic [31:0] len_d;

  assign len_d = (len_q << D_WIDTH) | 32'(byte_i);
  assign len_o = len_d;

  // Shift accepted header bytes in from the least significant end.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      len_q <= '0;
    end else if (shift_i) begin
      len_q <= len_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module   : instr_loader
//  Purpose  : Streams a length-prefixed image into instruction memory while
//             holding the CPU in reset. Optional trailing XOR checksum is
//             built when LOADER_CHECKSUM_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_loader
  import loader_pkg::*;
#(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 8,
  parameter int DEPTH   = 2001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [D_WIDTH-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               mem_we,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err
);

  state_e             state_q, state_d;
  logic [1:0]         hcnt_q, hcnt_d;
  logic [A_WIDTH-1:0] cnt_q, cnt_d;
  logic [A_WIDTH-1:0] n_q, n_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               hold_q, hold_d;
  logic               we_q, we_d;
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic [D_WIDTH-1:0] wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [D_WIDTH-1:0] csum_q, csum_d;
`endif

  logic        xfer;
  logic        hdr_clr;
  logic        hdr_shift;
  logic [31:0] hdr_len;

  assign in_ready  = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign xfer      = in_valid && in_ready;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign load_done = done_q;
  assign load_err  = err_q;

  loader_hdr_shift #(
    .D_WIDTH (D_WIDTH)
  ) u_hdr_shift (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (hdr_clr),
    .shift_i (hdr_shift),
    .byte_i  (in_data),
    .len_o   (hdr_len)
  );

  // Next-state, counter and write-port logic for the load sequence.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    done_d    = done_q;
    err_d     = err_q;
    hold_d    = hold_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hdr_clr   = 1'b0;
    hdr_shift = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      ST_HDR: begin
        if (xfer) begin
          hdr_shift = 1'b1;
          hcnt_d    = hcnt_q + 2'd1;
          if (hcnt_q == 2'(HDR_BYTES - 1)) begin
            if (hdr_len > 32'(DEPTH)) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end else if (hdr_len == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = ST_CSUM;
`else
              state_d = ST_DONE;
              done_d  = 1'b1;
              hold_d  = 1'b0;
`endif
            end else begin
              state_d = ST_DATA;
              n_d     = A_WIDTH'(hdr_len);
            end
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = in_data;
          cnt_d   = cnt_q + A_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ in_data;
`endif
          if (cnt_q + A_WIDTH'(1) == n_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
`endif
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (xfer) begin
          if (in_data == csum_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: begin
        // IDLE, DONE and ERR: only a start request moves the FSM.
        if (start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR)) begin
          state_d = ST_HDR;
          hcnt_d  = 2'd0;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          hdr_clr = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
    endcase
  end

  // State registers; reset wins over start and any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hcnt_q  <= 2'd0;
      cnt_q   <= '0;
      n_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_loader
//  Purpose  : Directed self-checking bench for instr_loader.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  int base;

  always #5 clk = ~clk;

  instr_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  // Count every write strobe, sampled mid-cycle.
  always @(negedge clk) if (mem_we === 1'b1) wr_count <= wr_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte after an optional idle gap (with optional start pulses
  // during the gap), wait for acceptance, then check the write port.
  task automatic send(input logic [7:0] b, input int gap, input bit st_in_gap,
                      input bit exp_we, input logic [31:0] exp_addr);
    int n;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'hxx;
      start    = st_in_gap;
      tick();
    end
    start    = st_in_gap;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $error("FAIL accept_timeout observed=%0d expected=<50", n);
    end
    tick();
    in_valid = 1'b0;
    start    = 1'b0;
    check("mem_we_after_accept", {31'd0, mem_we}, {31'd0, exp_we});
    if (exp_we) begin
      check("mem_addr", mem_addr, exp_addr);
      check("mem_wdata", {24'd0, mem_wdata}, {24'd0, b});
      tick();
      check("mem_we_one_cycle", {31'd0, mem_we}, 32'd0);
    end
  endtask

  task automatic send_hdr(input logic [31:0] len);
    send(len[31:24], 0, 1'b0, 1'b0, 0);
    send(len[23:16], 0, 1'b0, 1'b0, 0);
    send(len[15:8],  0, 1'b0, 1'b0, 0);
    send(len[7:0],   0, 1'b0, 1'b0, 0);
  endtask

  task automatic check_done(input string tag);
    tick();
    check({tag, "_done"}, {31'd0, load_done}, 32'd1);
    check({tag, "_err"},  {31'd0, load_err},  32'd0);
    check({tag, "_hold"}, {31'd0, cpu_hold},  32'd0);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic check_err(input string tag);
    tick();
    check({tag, "_err"},  {31'd0, load_err},  32'd1);
    check({tag, "_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_hold"}, {31'd0, cpu_hold},  32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, in_ready},  32'd0);
    check({tag, "_we"},    {31'd0, mem_we},    32'd0);
    check({tag, "_addr"},  mem_addr,           32'd0);
    check({tag, "_wdata"}, {24'd0, mem_wdata}, 32'd0);
    check({tag, "_done"},  {31'd0, load_done}, 32'd0);
    check({tag, "_err"},   {31'd0, load_err},  32'd0);
    check({tag, "_hold"},  {31'd0, cpu_hold},  32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Basic load of four bytes.
    base = wr_count;
    pulse_start();
    check("start_ready", {31'd0, in_ready}, 32'd1);
    check("start_hold", {31'd0, cpu_hold}, 32'd1);
    send_hdr(32'd4);
    send(8'hDE, 0, 1'b0, 1'b1, 0);
    send(8'hAD, 0, 1'b0, 1'b1, 1);
    send(8'hBE, 0, 1'b0, 1'b1, 2);
    send(8'hEF, 0, 1'b0, 1'b1, 3);
`ifdef LOADER_CHECKSUM_EN
    send(8'h22, 0, 1'b0, 1'b0, 0);
`endif
    check_done("basic");
    check("basic_writes", wr_count - base, 32'd4);

    // Oversize length (2002) aborts with no writes.
    base = wr_count;
    pulse_start();
    check("restart_clears_done", {31'd0, load_done}, 32'd0);
    send_hdr(32'd2002);
    check_err("oversize");
    repeat (2) tick();
    check("oversize_writes", wr_count - base, 32'd0);

    // Largest legal length (2001) enters DATA; abandon with reset.
    pulse_start();
    check("err_cleared_on_start", {31'd0, load_err}, 32'd0);
    send_hdr(32'd2001);
    check("max_len_ready", {31'd0, in_ready}, 32'd1);
    check("max_len_err", {31'd0, load_err}, 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset_outputs("rst_in_data_max");

    // Zero length: no writes.
    base = wr_count;
    pulse_start();
    send_hdr(32'd0);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00, 0, 1'b0, 1'b0, 0);
`endif
    check_done("zero_len");
    check("zero_len_writes", wr_count - base, 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum good and bad.
    pulse_start();
    send_hdr(32'd2);
    send(8'h12, 0, 1'b0, 1'b1, 0);
    send(8'h34, 0, 1'b0, 1'b1, 1);
    send(8'h26, 0, 1'b0, 1'b0, 0);
    check_done("csum_good");
    pulse_start();
    send_hdr(32'd2);
    send(8'h12, 0, 1'b0, 1'b1, 0);
    send(8'h34, 0, 1'b0, 1'b1, 1);
    send(8'h27, 0, 1'b0, 1'b0, 0);
    check_err("csum_bad");
`endif

    // Reset after two of four data bytes; reset beats a pending transfer.
    pulse_start();
    send_hdr(32'd4);
    send(8'h11, 0, 1'b0, 1'b1, 0);
    send(8'h22, 0, 1'b0, 1'b1, 1);
    base = wr_count;
    in_data = 8'h33; in_valid = 1'b1; start = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    check_reset_outputs("rst_mid_data");
    repeat (3) tick();
    check("rst_mid_no_writes", wr_count - base, 32'd0);
    base = wr_count;
    pulse_start();
    send_hdr(32'd4);
    send(8'h01, 0, 1'b0, 1'b1, 0);
    send(8'h02, 0, 1'b0, 1'b1, 1);
    send(8'h03, 0, 1'b0, 1'b1, 2);
    send(8'h04, 0, 1'b0, 1'b1, 3);
`ifdef LOADER_CHECKSUM_EN
    send(8'h04, 0, 1'b0, 1'b0, 0);
`endif
    check_done("reload");
    check("reload_writes", wr_count - base, 32'd4);

    // Random valid gaps and stray start pulses during DATA.
    base = wr_count;
    pulse_start();
    send_hdr(32'd5);
    send(8'hA0, $urandom_range(0, 3), 1'b1, 1'b1, 0);
    send(8'hA1, $urandom_range(0, 3), 1'b0, 1'b1, 1);
    send(8'hA2, $urandom_range(1, 3), 1'b1, 1'b1, 2);
    send(8'hA3, $urandom_range(0, 3), 1'b1, 1'b1, 3);
    send(8'hA4, $urandom_range(1, 3), 1'b1, 1'b1, 4);
`ifdef LOADER_CHECKSUM_EN
    send(8'hA4, $urandom_range(0, 2), 1'b0, 1'b0, 0);
`endif
    check_done("gappy");
    check("gappy_writes", wr_count - base, 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter A_WIDTH, default 32: width of the memory byte address.
REQ-002 Parameter D_WIDTH, default 8: width of one memory byte and of the input stream.
REQ-003 Parameter DEPTH, default 2001: number of writable bytes in the instruction memory.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 start  input  1: single-cycle request to begin a load.
REQ-007 in_data  input  D_WIDTH: stream byte.
REQ-008 in_valid  input  1: in_data valid.
REQ-009 in_ready  output  1: loader accepts in_data this cycle.
REQ-010 mem_we  output  1: byte write strobe to instruction memory.
REQ-011 mem_addr  output  A_WIDTH: byte address of the write.
REQ-012 mem_wdata  output  D_WIDTH: byte to write.
REQ-013 cpu_hold  output  1: holds the CPU in reset while a load is in progress.
REQ-014 load_done  output  1: level; last load completed successfully.
REQ-015 load_err  output  1: level; last load aborted.

Function
REQ-016 A byte transfers only in a cycle where in_valid and in_ready are both 1.
REQ-017 States are IDLE, HDR, DATA, CSUM, DONE, ERR; in_ready is 1 only in HDR, DATA and CSUM.
REQ-018 start in IDLE, DONE or ERR enters HDR, clears load_done, load_err, the byte counter and the checksum, and sets cpu_hold; start in HDR, DATA or CSUM is ignored.
REQ-019 HDR accepts exactly 4 bytes forming length N, first byte most significant, matching the big-endian word order the instruction memory uses for fetch.
REQ-020 After the 4th header byte: N > DEPTH enters ERR; N = 0 enters CSUM (or DONE without the checksum feature); otherwise enters DATA.
REQ-021 DATA accepts N bytes; the k-th accepted byte (k from 0) is written with mem_addr = k and mem_wdata = that byte.
REQ-022 mem_we, mem_addr and mem_wdata are registered; mem_we is high for exactly one cycle, the cycle after each DATA transfer, and is low otherwise.
REQ-023 After the N-th data byte is accepted the state moves to CSUM (or DONE) on the next edge; no further byte is accepted in DATA.
REQ-024 DONE sets load_done = 1 and clears cpu_hold; ERR sets load_err = 1 and keeps cpu_hold = 1.
REQ-025 The counter is A_WIDTH bits and cannot wrap, because N <= DEPTH is enforced before DATA.
REQ-026 No transfer occurs while in_valid = 0; the FSM waits indefinitely in HDR, DATA or CSUM.

Reset
REQ-027 rst takes priority over start and over any transfer.
REQ-028 Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, load_done 0, load_err 0, cpu_hold 1.
REQ-029 Reset during DATA abandons the load with no further mem_we; bytes already written remain in memory.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN: when defined, CSUM accepts one byte that is compared with the XOR of all N data bytes; equal enters DONE, unequal enters ERR.
REQ-031 When LOADER_CHECKSUM_EN is undefined, CSUM is unreachable, no checksum logic is built, and DATA (or N = 0) goes directly to DONE.

Structure
REQ-032 Shared package loader_pkg holds the state enum type and the HDR_BYTES = 4 constant.
REQ-033 One sub-module, loader_hdr_shift, assembles the 32-bit length from the header bytes; all other logic stays flat in instr_loader.

Verification
REQ-034 Reset, then start, then stream 00 00 00 04 DE AD BE EF -> writes DE, AD, BE, EF to addresses 0, 1, 2, 3, each mem_we one cycle after acceptance; load_done = 1; cpu_hold = 0.
REQ-035 Header 00 00 07 D2 (N = 2002) -> ERR; load_err = 1; no mem_we; cpu_hold = 1.
REQ-036 Header 00 00 00 00 -> DONE with zero writes (with LOADER_CHECKSUM_EN, checksum byte 00 is required first).
REQ-037 With LOADER_CHECKSUM_EN: payload 12 34 with checksum 26 -> DONE; same payload with checksum 27 -> ERR.
REQ-038 rst after 2 of 4 data bytes -> no further mem_we; outputs at reset values; a new start then loads correctly.
REQ-039 in_valid toggled randomly, plus start pulses during DATA -> byte order and addresses unchanged, start ignored.
